// File: rtl/day1_topn_tracker.sv
// Streaming group-sum tracker keeping the TOP_N largest sums (sorted, with group index) and their total.
// Optional build macro TOPN_ZERO_SEP_EN: an accepted zero-valued beat closes the group instead of adding.
module day1_topn_tracker #(
    parameter int DATA_W = 32,
    parameter int SUM_W  = 40,
    parameter int IDX_W  = 16,
    parameter int TOP_N  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    input  logic                   flush,
    input  logic                   clear,
    output logic [TOP_N*SUM_W-1:0] top_sum,
    output logic [TOP_N*IDX_W-1:0] top_idx,
    output logic [SUM_W-1:0]       total_sum,
    output logic                   total_vld,
    output logic [IDX_W-1:0]       grp_count,
    output logic                   overflow
);

    localparam int CNT_W = (TOP_N > 1) ? $clog2(TOP_N) : 1;
    localparam int EW    = ((DATA_W > SUM_W) ? DATA_W : SUM_W) + 1;
    localparam logic [EW-1:0] SUM_MAX = {{(EW-SUM_W){1'b0}}, {SUM_W{1'b1}}};

    typedef enum logic [1:0] {ACCUM, COMMIT, TOTAL} state_e;

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   sum_q [TOP_N];
    logic [SUM_W-1:0]   sum_d [TOP_N];
    logic [IDX_W-1:0]   idx_q [TOP_N];
    logic [IDX_W-1:0]   idx_d [TOP_N];
    logic [SUM_W-1:0]   cur_sum_q, cur_sum_d;
    logic               has_data_q, has_data_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0]   grp_q, grp_d;
    logic [SUM_W-1:0]   total_q, total_d;
    logic               vld_q, vld_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept, close, close_req, last_cnt, beat_ovf;
    logic [DATA_W-1:0]  add_val;
    logic [EW-1:0]      beat_ext;
    logic [SUM_W-1:0]   beat_sat, sel, base;
    logic [SUM_W:0]     tot_ext;
    logic [TOP_N-1:0]   gt;

    assign accept = in_valid & in_ready;

`ifdef TOPN_ZERO_SEP_EN
    assign close   = in_last | (in_data == '0);
    assign add_val = (in_data == '0) ? '0 : in_data;
`else
    assign close   = in_last;
    assign add_val = in_data;
`endif

    assign beat_ext  = EW'(cur_sum_q) + EW'(add_val);
    assign beat_ovf  = beat_ext > SUM_MAX;
    assign beat_sat  = beat_ovf ? '1 : beat_ext[SUM_W-1:0];
    assign close_req = (accept & close) | (~accept & flush & has_data_q);
    assign last_cnt  = (cnt_q == CNT_W'(TOP_N - 1));

    always_comb begin
        sel = '0;
        for (int unsigned k = 0; k < TOP_N; k++) begin
            if (cnt_q == CNT_W'(k)) sel = sum_q[k];
        end
        base    = (cnt_q == '0) ? '0 : total_q;
        tot_ext = {1'b0, base} + {1'b0, sel};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (close_req) state_d = COMMIT;
                COMMIT:  state_d = TOTAL;
                TOTAL:   if (last_cnt) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == ACCUM);
        total_sum = total_q;
        total_vld = vld_q;
        grp_count = grp_q;
        overflow  = ovf_q;
        for (int unsigned k = 0; k < TOP_N; k++) begin
            top_sum[k*SUM_W +: SUM_W] = sum_q[k];
            top_idx[k*IDX_W +: IDX_W] = idx_q[k];
        end
    end

    // List is sorted descending, so gt[] is a run of zeros followed by ones;
    // the first set bit is the insert slot and every later set slot takes its upper neighbour.
    always_comb begin
        for (int unsigned k = 0; k < TOP_N; k++) gt[k] = cur_sum_q > sum_q[k];
    end

    always_comb begin
        sum_d      = sum_q;
        idx_d      = idx_q;
        cur_sum_d  = cur_sum_q;
        has_data_d = has_data_q;
        cur_idx_d  = cur_idx_q;
        grp_d      = grp_q;
        total_d    = total_q;
        vld_d      = vld_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    cur_sum_d  = beat_sat;
                    has_data_d = 1'b1;
                    if (beat_ovf) ovf_d = 1'b1;
                end
            end
            COMMIT: begin
                if (gt[0]) begin
                    sum_d[0] = cur_sum_q;
                    idx_d[0] = cur_idx_q;
                end
                for (int unsigned k = 1; k < TOP_N; k++) begin
                    if (gt[k]) begin
                        sum_d[k] = gt[k-1] ? sum_q[k-1] : cur_sum_q;
                        idx_d[k] = gt[k-1] ? idx_q[k-1] : cur_idx_q;
                    end
                end
                cur_idx_d  = cur_idx_q + 1'b1;
                grp_d      = grp_q + 1'b1;
                cur_sum_d  = '0;
                has_data_d = 1'b0;
                vld_d      = 1'b0;
                cnt_d      = '0;
            end
            TOTAL: begin
                total_d = tot_ext[SUM_W] ? '1 : tot_ext[SUM_W-1:0];
                if (tot_ext[SUM_W]) ovf_d = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (last_cnt) vld_d = 1'b1;
            end
            default: ;
        endcase
        if (clear) begin
            for (int unsigned k = 0; k < TOP_N; k++) begin
                sum_d[k] = '0;
                idx_d[k] = '0;
            end
            cur_sum_d  = '0;
            has_data_d = 1'b0;
            cur_idx_d  = '0;
            grp_d      = '0;
            total_d    = '0;
            vld_d      = 1'b1;
            ovf_d      = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TOP_N; k++) begin
                sum_q[k] <= '0;
                idx_q[k] <= '0;
            end
            cur_sum_q  <= '0;
            has_data_q <= 1'b0;
            cur_idx_q  <= '0;
            grp_q      <= '0;
            total_q    <= '0;
            vld_q      <= 1'b1;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            cur_sum_q  <= cur_sum_d;
            has_data_q <= has_data_d;
            cur_idx_q  <= cur_idx_d;
            grp_q      <= grp_d;
            total_q    <= total_d;
            vld_q      <= vld_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_day1_topn_tracker.sv
// Scoreboard bench for day1_topn_tracker: directed groups push hand-computed results, a monitor checks each total.
module tb_day1_topn_tracker;

    localparam int DW = 32;
    localparam int SW = 40;
    localparam int IW = 16;
    localparam int N  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, in_valid, in_ready, in_last, flush, clear;
    logic [DW-1:0]   in_data;
    logic [N*SW-1:0] top_sum;
    logic [N*IW-1:0] top_idx;
    logic [SW-1:0]   total_sum;
    logic            total_vld, overflow;
    logic [IW-1:0]   grp_count;

    logic            v8, r8, l8, f8, c8, tv8, ov8;
    logic [DW-1:0]   d8;
    logic [N*8-1:0]  ts8;
    logic [N*IW-1:0] ti8;
    logic [7:0]      tot8;
    logic [IW-1:0]   gc8;

    day1_topn_tracker #(.DATA_W(DW), .SUM_W(SW), .IDX_W(IW), .TOP_N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .flush(flush), .clear(clear), .top_sum(top_sum), .top_idx(top_idx),
        .total_sum(total_sum), .total_vld(total_vld), .grp_count(grp_count), .overflow(overflow)
    );

    day1_topn_tracker #(.DATA_W(DW), .SUM_W(8), .IDX_W(IW), .TOP_N(N)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_data(d8),
        .in_last(l8), .flush(f8), .clear(c8), .top_sum(ts8), .top_idx(ti8),
        .total_sum(tot8), .total_vld(tv8), .grp_count(gc8), .overflow(ov8)
    );

    typedef struct {
        logic [N*SW-1:0] s;
        logic [N*IW-1:0] i;
        logic [SW-1:0]   t;
        logic [IW-1:0]   g;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    logic prev_vld = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic push(input logic [SW-1:0] s0, s1, s2, input logic [IW-1:0] i0, i1, i2,
                        input logic [SW-1:0] tot, input logic [IW-1:0] g);
        exp_t e;
        e.s = {s2, s1, s0};
        e.i = {i2, i1, i0};
        e.t = tot;
        e.g = g;
        sb.push_back(e);
    endtask

    // Monitor: every rising edge of total_vld outside reset is one result to score
    always @(negedge clk) begin
        if (rst_n && total_vld && !prev_vld) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got total=%0d expected no result", total_sum);
            end else begin
                mon_e = sb.pop_front();
                chk("top_sum", top_sum, mon_e.s);
                chk("top_idx", top_idx, mon_e.i);
                chk("total_sum", total_sum, mon_e.t);
                chk("grp_count", grp_count, mon_e.g);
                chk("overflow", overflow, 0);
            end
        end
        prev_vld = total_vld;
    end

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Leaves in_valid high so back-to-back calls model a continuously valid source
    task automatic beat(input logic [DW-1:0] d, input logic last, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waits    = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL beat_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic do_flush();
        int n = 0;
        idle();
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_sb();
        int n = 0;
        while ((sb.size() != 0 || !total_vld) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic check_zero(input string p);
        chk({p, "_top_sum"}, top_sum, 0);
        chk({p, "_top_idx"}, top_idx, 0);
        chk({p, "_total"}, total_sum, 0);
        chk({p, "_total_vld"}, total_vld, 1);
        chk({p, "_in_ready"}, in_ready, 1);
        chk({p, "_grp_count"}, grp_count, 0);
        chk({p, "_overflow"}, overflow, 0);
    endtask

    task automatic run_test1();
        int w;
        beat(1000, 0, w); beat(2000, 0, w);
        push(6000, 0, 0, 0, 0, 0, 6000, 1);                   beat(3000, 1, w);
        push(6000, 4000, 0, 0, 1, 0, 10000, 2);               beat(4000, 1, w);
        beat(5000, 0, w);
        push(11000, 6000, 4000, 2, 0, 1, 21000, 3);           beat(6000, 1, w);
        beat(7000, 0, w); beat(8000, 0, w);
        push(24000, 11000, 6000, 3, 2, 0, 41000, 4);          beat(9000, 1, w);
        push(24000, 11000, 10000, 3, 2, 4, 45000, 5);         beat(10000, 1, w);
        idle();
        wait_sb();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; flush = 1'b0; clear = 1'b0; idle();
        v8 = 1'b0; d8 = '0; l8 = 1'b0; f8 = 1'b0; c8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_zero("reset");

        run_test1();

        do_clear();
        check_zero("clear");
`ifdef TOPN_ZERO_SEP_EN
        beat(1000, 0, w); beat(2000, 0, w); beat(3000, 0, w);
        push(6000, 0, 0, 0, 0, 0, 6000, 1);                   beat(0, 0, w);
        beat(4000, 0, w);
        push(6000, 4000, 0, 0, 1, 0, 10000, 2);               beat(0, 0, w);
        beat(5000, 0, w); beat(6000, 0, w);
        push(11000, 6000, 4000, 2, 0, 1, 21000, 3);           beat(0, 0, w);
        beat(7000, 0, w); beat(8000, 0, w); beat(9000, 0, w);
        push(24000, 11000, 6000, 3, 2, 0, 41000, 4);          beat(0, 0, w);
        beat(10000, 0, w);
        push(24000, 11000, 10000, 3, 2, 4, 45000, 5);
        do_flush();
        wait_sb();
`else
        beat(0, 0, w);
        push(5, 0, 0, 0, 0, 0, 5, 1);                         beat(5, 1, w);
        push(5, 0, 0, 0, 0, 0, 5, 2);                         beat(0, 1, w);
        flush = 1'b1;
        beat(7, 0, w);
        flush = 1'b0;
        idle();
        push(7, 5, 0, 2, 0, 0, 12, 3);
        do_flush();
        wait_sb();
        do_flush();
        repeat (6) @(posedge clk);
        #1;
        chk("empty_flush_grp_count", grp_count, 3);
        chk("empty_flush_in_ready", in_ready, 1);
`endif

        do_clear();
        push(500, 0, 0, 0, 0, 0, 500, 1);                     beat(500, 1, w);
        push(500, 500, 0, 0, 1, 0, 1000, 2);                  beat(500, 1, w);
        push(700, 500, 500, 2, 0, 1, 1700, 3);                beat(700, 1, w);
        idle();
        wait_sb();

        do_clear();
        beat(1, 0, w);
        push(3, 0, 0, 0, 0, 0, 3, 1);                         beat(2, 1, w);
        push(30, 3, 0, 1, 0, 0, 33, 2);                       beat(30, 1, w);
        chk("stall_after_g0", w, 1 + N);
        beat(4, 0, w);
        chk("stall_after_g1", w, 1 + N);
        beat(5, 0, w);
        push(30, 15, 3, 1, 2, 0, 48, 3);                      beat(6, 1, w);
        idle();
        wait_sb();

        v8 = 1'b1; d8 = 200; l8 = 1'b0;
        @(posedge clk); #1;
        d8 = 100; l8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0; l8 = 1'b0; d8 = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("sat_top0", ts8[7:0], 255);
        chk("sat_overflow", ov8, 1);
        chk("sat_total", tot8, 255);
        chk("sat_grp_count", gc8, 1);
        c8 = 1'b1;
        @(posedge clk); #1;
        c8 = 1'b0;
        chk("sat_clear_top", ts8, 0);
        chk("sat_clear_total", tot8, 0);
        chk("sat_clear_overflow", ov8, 0);
        chk("sat_clear_grp", gc8, 0);
        chk("sat_clear_ready", r8, 1);

        do_clear();
        beat(1000, 0, w); beat(2000, 0, w); beat(3000, 1, w);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_total_vld", total_vld, 0);
        #1 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_test1();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
